// File: rtl/sigma_tile_pkg.sv
// sigma_tile shared definitions.
// Holds the SFR register map constants and the interrupt controller's
// line-count default and FSM state type, so the SFR block and irq_ctrl
// agree on one source of truth.
// No ports (package).
package sigma_tile_pkg;

    // SFR word addresses feeding the interrupt controller
    localparam logic [7:0] SFR_IRQ_EN_ADDR   = 8'h10;
    localparam logic [7:0] SFR_TIMER_ADDR    = 8'h14;
    localparam logic [7:0] SFR_SGI_ADDR      = 8'h18;

    // Default log2 of the number of interrupt lines
    localparam int IRQ_NUM_POW_DEF = 4;

    // Interrupt controller FSM states
    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_REQ     = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set bit of the mask wins.
// Ports:
//   mask_bi  - candidate mask, 2**IDX_W bits
//   valid_o  - at least one mask bit set
//   idx_bo   - index of the lowest set bit (0 when mask is empty)
module irq_prio_enc #(
    parameter int IDX_W = 4
) (
    input  logic [(2**IDX_W)-1:0] mask_bi,
    output logic                  valid_o,
    output logic [IDX_W-1:0]      idx_bo
);

    localparam int N = 2**IDX_W;

    // lower_any[i] is set when any bit below i is set; grant is one-hot
    logic [N-1:0] lower_any;
    logic [N-1:0] grant;

    assign lower_any[0] = 1'b0;
    assign grant[0]     = mask_bi[0];

    genvar gi;
    generate
        for (gi = 1; gi < N; gi++) begin : g_chain
            assign lower_any[gi] = lower_any[gi-1] | mask_bi[gi-1];
            assign grant[gi]     = mask_bi[gi] & ~lower_any[gi];
        end
    endgenerate

    // Grant is one-hot, so OR-ing the indices of set grant bits yields the index
    always_comb begin
        idx_bo = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                idx_bo = idx_bo | IDX_W'(i);
            end
        end
    end

    assign valid_o = |mask_bi;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-detects external lines, merges timer and
// software-generated events into a pending register, and presents the
// highest-priority enabled pending line to the core with a req/ack/done
// handshake (no nesting).
// Ports:
//   clk_i        - clock
//   rst_i        - asynchronous active-low reset
//   irq_en_bi    - per-line enable mask
//   irq_bi       - external interrupt lines (rising edge = event)
//   irq_timer_i  - timer event pulse, targets TIMER_IRQ_LINE
//   sgi_req_i    - software interrupt pulse
//   sgi_code_bi  - software interrupt target line
//   irq_req_o    - request to core
//   irq_code_bo  - requested line index
//   irq_ack_i    - core accepts request
//   irq_done_i   - core finished handler
//   pending_bo   - pending register readback
module irq_ctrl
    import sigma_tile_pkg::*;
#(
    parameter int IRQ_NUM_POW    = IRQ_NUM_POW_DEF,
    parameter int TIMER_IRQ_LINE = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [(2**IRQ_NUM_POW)-1:0]  irq_en_bi,
    input  logic [(2**IRQ_NUM_POW)-1:0]  irq_bi,
    input  logic                         irq_timer_i,
    input  logic                         sgi_req_i,
    input  logic [IRQ_NUM_POW-1:0]       sgi_code_bi,
    output logic                         irq_req_o,
    output logic [IRQ_NUM_POW-1:0]       irq_code_bo,
    input  logic                         irq_ack_i,
    input  logic                         irq_done_i,
    output logic [(2**IRQ_NUM_POW)-1:0]  pending_bo
);

    localparam int N = 2**IRQ_NUM_POW;

    irq_state_e             state_reg, state_next;
    logic [IRQ_NUM_POW-1:0] code_reg, code_next;
    logic [N-1:0]           pending_reg, pending_next;
    logic [N-1:0]           irq_prev_reg;
    logic [N-1:0]           event_vec;
    logic [N-1:0]           clear_vec;
    logic [N-1:0]           cand_mask;
    logic                   cand_valid;
    logic [IRQ_NUM_POW-1:0] cand_idx;

    // Per-line event and clear terms
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_line
            assign event_vec[gi] = (irq_bi[gi] & ~irq_prev_reg[gi])
                                 | (irq_timer_i && (gi == TIMER_IRQ_LINE))
                                 | (sgi_req_i && (sgi_code_bi == IRQ_NUM_POW'(gi)));
            assign clear_vec[gi] = (state_reg == IRQ_REQ) && irq_ack_i
                                 && (code_reg == IRQ_NUM_POW'(gi));
        end
    endgenerate

    // Set wins over clear so an event arriving with the ack is not lost
    assign pending_next = (pending_reg & ~clear_vec) | event_vec;
    assign cand_mask    = pending_reg & irq_en_bi;

    irq_prio_enc #(
        .IDX_W (IRQ_NUM_POW)
    ) u_prio_enc (
        .mask_bi (cand_mask),
        .valid_o (cand_valid),
        .idx_bo  (cand_idx)
    );

    always_comb begin
        state_next = state_reg;
        code_next  = code_reg;
        case (state_reg)
            IRQ_IDLE: begin
                if (cand_valid) begin
                    state_next = IRQ_REQ;
                    code_next  = cand_idx;
                end
            end
            IRQ_REQ: begin
                // Code is frozen here; only the ack moves us on
                if (irq_ack_i) begin
                    state_next = IRQ_SERVICE;
                end
            end
            IRQ_SERVICE: begin
                if (irq_done_i) begin
                    state_next = IRQ_IDLE;
                end
            end
            default: begin
                state_next = IRQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg    <= IRQ_IDLE;
            code_reg     <= '0;
            pending_reg  <= '0;
            irq_prev_reg <= '0;
        end else begin
            state_reg    <= state_next;
            code_reg     <= code_next;
            pending_reg  <= pending_next;
            irq_prev_reg <= irq_bi;
        end
    end

    assign irq_req_o   = (state_reg == IRQ_REQ);
    assign irq_code_bo = code_reg;
    assign pending_bo  = pending_reg;

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

    localparam int POW   = 4;
    localparam int N     = 2**POW;
    localparam int TIMER = 0;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [N-1:0]    irq_en_bi;
    logic [N-1:0]    irq_bi;
    logic            irq_timer_i;
    logic            sgi_req_i;
    logic [POW-1:0]  sgi_code_bi;
    logic            irq_req_o;
    logic [POW-1:0]  irq_code_bo;
    logic            irq_ack_i;
    logic            irq_done_i;
    logic [N-1:0]    pending_bo;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase 0=idle, 1=requesting, 2=in handler
    int              m_phase;
    int              m_code;
    logic [N-1:0]    m_pend;
    logic [N-1:0]    m_prev;
    int              exp_q[$];

    irq_ctrl #(
        .IRQ_NUM_POW    (POW),
        .TIMER_IRQ_LINE (TIMER)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .irq_en_bi   (irq_en_bi),
        .irq_bi      (irq_bi),
        .irq_timer_i (irq_timer_i),
        .sgi_req_i   (sgi_req_i),
        .sgi_code_bi (sgi_code_bi),
        .irq_req_o   (irq_req_o),
        .irq_code_bo (irq_code_bo),
        .irq_ack_i   (irq_ack_i),
        .irq_done_i  (irq_done_i),
        .pending_bo  (pending_bo)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_phase = 0;
        m_code  = 0;
        m_pend  = '0;
        m_prev  = '0;
        exp_q.delete();
    endtask

    // One clock edge of the behavioural model, using the inputs seen at that edge
    task automatic model_step();
        logic [N-1:0] ev;
        logic [N-1:0] cand;
        ev = irq_bi & ~m_prev;
        if (irq_timer_i) ev[TIMER] = 1'b1;
        if (sgi_req_i) ev[int'(sgi_code_bi)] = 1'b1;
        m_prev = irq_bi;
        if (m_phase == 1) begin
            if (irq_ack_i) begin
                m_pend[m_code] = 1'b0;
                m_phase = 2;
            end
        end else if (m_phase == 2) begin
            if (irq_done_i) m_phase = 0;
        end else begin
            cand = m_pend & irq_en_bi;
            if (cand != '0) begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (cand[k]) m_code = k;
                end
                m_phase = 1;
                exp_q.push_back(m_code);
            end
        end
        m_pend = m_pend | ev;
    endtask

    task automatic cyc();
        @(posedge clk_i);
        if (rst_i) model_step();
        #1;
        irq_timer_i = 1'b0;
        sgi_req_i   = 1'b0;
        irq_ack_i   = 1'b0;
        irq_done_i  = 1'b0;
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 8 && !irq_req_o; i++) cyc();
        chk({name, "_req_timeout"}, 32'(irq_req_o), 32'd1);
    endtask

    task automatic do_reset(input string name);
        rst_i = 1'b0;
        m_reset();
        #1;
        chk({name, "_rst_req"}, 32'(irq_req_o), 32'd0);
        chk({name, "_rst_pend"}, 32'(pending_bo), 32'd0);
        cyc();
        rst_i = 1'b1;
    endtask

    task automatic ack_done();
        irq_ack_i = 1'b1;
        cyc();
        irq_done_i = 1'b1;
        cyc();
    endtask

    // Monitor: compares every cycle and pops the scoreboard on each new request
    initial begin
        logic prev_req;
        int   exp_code;
        prev_req = 1'b0;
        forever begin
            @(negedge clk_i);
            chk("req", 32'(irq_req_o), 32'(m_phase == 1));
            chk("code", 32'(irq_code_bo), 32'(m_code));
            chk("pending", 32'(pending_bo), 32'(m_pend));
            if (irq_req_o && !prev_req) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_req: got code %0d expected no request at %0t", irq_code_bo, $time);
                end else begin
                    exp_code = exp_q.pop_front();
                    chk("sb_code", 32'(irq_code_bo), 32'(exp_code));
                end
            end
            prev_req = irq_req_o;
        end
    end

    initial begin
        rst_i       = 1'b0;
        irq_en_bi   = '0;
        irq_bi      = '0;
        irq_timer_i = 1'b0;
        sgi_req_i   = 1'b0;
        sgi_code_bi = '0;
        irq_ack_i   = 1'b0;
        irq_done_i  = 1'b0;
        m_reset();
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_req", 32'(irq_req_o), 32'd0);
        chk("reset_code", 32'(irq_code_bo), 32'd0);
        chk("reset_pend", 32'(pending_bo), 32'd0);
        rst_i = 1'b1;
        cyc();

        // Basic flow: request appears two edges after the input edge
        irq_en_bi = 16'h0004;
        irq_bi[2] = 1'b1;
        cyc();
        cyc();
        chk("basic_req", 32'(irq_req_o), 32'd1);
        chk("basic_code", 32'(irq_code_bo), 32'd2);
        irq_ack_i = 1'b1;
        cyc();
        chk("basic_ack_pend", 32'(pending_bo), 32'd0);
        irq_done_i = 1'b1;
        cyc();
        irq_bi = '0;
        cyc();
        $display("scenario basic done");

        // Priority: lines 5 and 3 together
        irq_en_bi = 16'hFFFF;
        irq_bi[5] = 1'b1;
        irq_bi[3] = 1'b1;
        wait_req("prio1");
        chk("prio_first", 32'(irq_code_bo), 32'd3);
        ack_done();
        wait_req("prio2");
        chk("prio_second", 32'(irq_code_bo), 32'd5);
        ack_done();
        irq_bi = '0;
        cyc();
        $display("scenario priority done");

        // Masked line stays pending until enabled
        irq_en_bi   = 16'h0000;
        sgi_req_i   = 1'b1;
        sgi_code_bi = 4'd7;
        repeat (3) cyc();
        chk("mask_pend", 32'(pending_bo), 32'h0080);
        chk("mask_noreq", 32'(irq_req_o), 32'd0);
        irq_en_bi = 16'h0080;
        wait_req("mask");
        chk("mask_code", 32'(irq_code_bo), 32'd7);
        ack_done();
        $display("scenario masked done");

        // Timer pulse during service of line 4
        irq_en_bi   = 16'hFFFF;
        sgi_req_i   = 1'b1;
        sgi_code_bi = 4'd4;
        wait_req("svc");
        chk("svc_code4", 32'(irq_code_bo), 32'd4);
        irq_ack_i = 1'b1;
        cyc();
        irq_timer_i = 1'b1;
        cyc();
        cyc();
        chk("svc_timer_pend", 32'(pending_bo[TIMER]), 32'd1);
        chk("svc_noreq", 32'(irq_req_o), 32'd0);
        irq_done_i = 1'b1;
        cyc();
        wait_req("svc_timer");
        chk("svc_code0", 32'(irq_code_bo), 32'd0);
        ack_done();
        $display("scenario timer-in-service done");

        // Set/clear collision on line 1
        sgi_req_i   = 1'b1;
        sgi_code_bi = 4'd1;
        wait_req("coll");
        chk("coll_code", 32'(irq_code_bo), 32'd1);
        irq_ack_i   = 1'b1;
        sgi_req_i   = 1'b1;
        sgi_code_bi = 4'd1;
        cyc();
        chk("coll_pend", 32'(pending_bo[1]), 32'd1);
        irq_done_i = 1'b1;
        cyc();
        wait_req("coll_again");
        chk("coll_code_again", 32'(irq_code_bo), 32'd1);
        ack_done();
        $display("scenario collision done");

        // Reset during REQ discards everything
        sgi_req_i   = 1'b1;
        sgi_code_bi = 4'd6;
        wait_req("rst");
        do_reset("rst_mid");
        repeat (4) cyc();
        chk("rst_noreq", 32'(irq_req_o), 32'd0);
        $display("scenario reset-in-req done");

        // Line held high through reset is seen as an edge after release
        irq_bi[9] = 1'b1;
        cyc();
        do_reset("rst_hold");
        wait_req("hold");
        chk("hold_code", 32'(irq_code_bo), 32'd9);
        ack_done();
        irq_bi = '0;
        cyc();
        $display("scenario held-through-reset done");

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) do_reset("rand");
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 15) == 0) irq_bi[b] = ~irq_bi[b];
            end
            if ($urandom_range(0, 40) == 0) irq_en_bi = N'($urandom);
            irq_timer_i = ($urandom_range(0, 9) == 0);
            sgi_req_i   = ($urandom_range(0, 7) == 0);
            sgi_code_bi = POW'($urandom_range(0, N - 1));
            irq_ack_i   = irq_req_o ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
            irq_done_i  = ($urandom_range(0, 3) == 0);
            cyc();
        end
        $display("random phase done");

        // Drain: stop events, enable all, keep acking and finishing
        irq_bi    = '0;
        irq_en_bi = 16'hFFFF;
        for (int n = 0; n < 100; n++) begin
            irq_ack_i  = 1'b1;
            irq_done_i = 1'b1;
            cyc();
        end
        @(negedge clk_i);
        #1;
        chk("drain_pend", 32'(pending_bo), 32'd0);
        chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter IRQ_NUM_POW, default 4: number of interrupt lines is 2**IRQ_NUM_POW.
REQ-002 Parameter TIMER_IRQ_LINE, default 0: line index set by the timer pulse.
REQ-003 Ports:
- clk_i, input, 1: sole clock; all state on rising edge.
- rst_i, input, 1: asynchronous, active-low reset.
- irq_en_bi, input, 2**IRQ_NUM_POW: per-line enable mask from the SFR block.
- irq_bi, input, 2**IRQ_NUM_POW: external interrupt lines, synchronous to clk_i; the rising edge is the event.
- irq_timer_i, input, 1: one-cycle timer event pulse.
- sgi_req_i, input, 1: one-cycle software-generated interrupt pulse.
- sgi_code_bi, input, IRQ_NUM_POW: SGI target line, valid with sgi_req_i.
- irq_req_o, output, 1: interrupt request to core.
- irq_code_bo, output, IRQ_NUM_POW: line being requested.
- irq_ack_i, input, 1: core accepts the request.
- irq_done_i, input, 1: core finished the handler (return from interrupt).
- pending_bo, output, 2**IRQ_NUM_POW: pending register, for debug and readback.

Function
REQ-004 Edge detector: a registered copy of irq_bi is kept; event on line k when irq_bi[k]=1 and the previous value was 0.
REQ-005 pending[k] is set on the clock edge that follows any event on k: edge, timer pulse (k=TIMER_IRQ_LINE), or SGI (k=sgi_code_bi).
REQ-006 Pending bits are set regardless of irq_en_bi; a disabled line stays pending and is never presented.
REQ-007 Candidate set = pending & irq_en_bi; the lowest index has the highest priority.
REQ-008 FSM states: IDLE, REQ, SERVICE.
REQ-009 IDLE: if the candidate set is non-empty, go to REQ and latch the winning index into irq_code_bo on the same edge.
- irq_req_o goes high one cycle after pending is visible.
REQ-010 REQ: irq_req_o=1; irq_code_bo is held stable until ack.
- Enable removal and higher-priority arrivals do not withdraw or change the request.
REQ-011 REQ with irq_ack_i=1: clear pending[irq_code_bo], go to SERVICE, and drop irq_req_o on that edge.
REQ-012 SERVICE: irq_req_o=0; no new request (no nesting); irq_done_i=1 returns the FSM to IDLE.
REQ-013 irq_ack_i outside REQ and irq_done_i outside SERVICE are ignored.
REQ-014 A set and a clear of the same bit on the same edge leave the bit set (the new event is not lost).
REQ-015 Multiple events on the same edge all set their bits; repeated events on an already pending line merge into one.
REQ-016 irq_code_bo keeps its last value outside REQ.
REQ-017 Worst-case latency from the event edge to irq_req_o is 2 cycles with the FSM in IDLE.

Reset
REQ-018 While rst_i=0, asynchronously:
- FSM=IDLE.
- pending=0; pending_bo=0.
- edge register=0.
- irq_req_o=0; irq_code_bo=0.
REQ-019 Reset mid-operation (REQ or SERVICE) discards the outstanding request and all pending events.
REQ-020 A line held high through reset deassertion is detected as an event on the first edge after release.

Structure
REQ-021 The FSM state enum and the IRQ_NUM_POW default belong in the shared sigma_tile package/header, beside the SFR constants.
REQ-022 The priority encoder is a separate combinational sub-module, irq_prio_enc: mask in; valid and index out.
REQ-023 irq_ctrl sits directly downstream of the SFR block, fed by its irq_en, irq_timer and sgi_req/sgi_code outputs.

Verification
REQ-024 Bench scenarios:
- Basic flow: en=16'h0004, rising edge on irq_bi[2] -> irq_req_o=1 with code=2 two cycles later; ack -> pending_bo=0; done -> IDLE.
- Priority: en=16'hFFFF, simultaneous edges on lines 5 and 3 -> code=3 first; after ack and done -> code=5.
- Masked line: en=16'h0000, SGI code=7 -> pending_bo=16'h0080, no request; set en=16'h0080 -> request with code=7.
- Timer pulse during SERVICE of line 4 (TIMER_IRQ_LINE=0) -> pending[0] set, irq_req_o stays 0 until done; request with code=0 follows.
- Set/clear collision: SGI to line 1 on the same cycle as ack of line 1 -> pending[1] remains 1 and is re-requested after done.
- Reset during REQ: rst_i low for 1 cycle -> irq_req_o=0 and pending_bo=0 immediately; no request after release.
